bus_write_receiver: RTL and testbench

- Receiving end of the system data bus that the octal tristate buffers drive.
- Watches I/O write cycles on the 8-bit data bus and captures bytes written to one decoded port address.
- Queues captured bytes in a small FIFO and presents them to a downstream consumer over a valid/ready handshake.
- Flags undriven-bus samples and overflow as sticky status bits.

---
 rtl/bus_write_receiver_if.sv | 25 ++
 rtl/bus_write_receiver.sv | 96 +++++++++
 tb/tb_bus_write_receiver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_write_receiver_if.sv
// rtl/bus_write_receiver_if.sv - I/O write bus, output stream and status signals of the write receiver
interface bus_write_receiver_if #(
  parameter int PTR_W = 2
);
  logic             iow_n;
  logic [9:0]       addr;
  logic [7:0]       d;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             float_err;
  logic             clr_status;

  modport master (
    output iow_n, addr, d, out_ready, clr_status,
    input  out_data, out_valid, count, overflow, float_err
  );

  modport slave (
    input  iow_n, addr, d, out_ready, clr_status,
    output out_data, out_valid, count, overflow, float_err
  );
endinterface

// File: rtl/bus_write_receiver.sv
// rtl/bus_write_receiver.sv - captures I/O writes to one port address into a small FIFO
// Strobe is synchronised, the bus is shadowed while it is low, and the byte is pushed on its synced rising edge.
module bus_write_receiver #(
  parameter logic [9:0] PORT_ADDR = 10'h060,
  parameter int         DEPTH     = 4,
  parameter int         PTR_W     = 2
) (
  input logic                clk,
  input logic                reset,
  bus_write_receiver_if.slave bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             s1, s2, s_prev;
  logic [9:0]       sh_addr;
  logic [7:0]       sh_data;
  logic             sh_bad;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [PTR_W:0]   cnt, cnt_next;
  logic             valid_q, ov_q, fe_q;
  logic [7:0]       data_q, head_next;
  logic             d_bad, write_end, push_req, pop, push_ok;

  // A floating bus reads as the pull-up value and is remembered as bad.
  assign d_bad     = $isunknown(bus.d);
  assign write_end = !s_prev && s2;
  assign push_req  = write_end && (sh_addr == PORT_ADDR);
  assign pop       = valid_q && bus.out_ready;
  assign push_ok   = push_req && ((cnt != FULL_CNT) || pop);

  always_comb begin
    rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_next = cnt;
    if (push_ok && !pop)
      cnt_next = cnt + 1'b1;
    else if (pop && !push_ok)
      cnt_next = cnt - 1'b1;
    // The new head is the incoming byte only when it lands in the head slot this cycle.
    head_next = (push_ok && (wr_ptr == rd_next)) ? sh_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= sh_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s_prev  <= 1'b1;
      sh_addr <= '0;
      sh_data <= '0;
      sh_bad  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      s1     <= bus.iow_n;
      s2     <= s1;
      s_prev <= s2;
      if (!s2) begin
        sh_addr <= bus.addr;
        sh_data <= d_bad ? 8'hFF : bus.d;
        sh_bad  <= d_bad;
      end
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_next;
      cnt     <= cnt_next;
      valid_q <= (cnt_next != '0);
      if (cnt_next != '0)
        data_q <= head_next;
      // Set beats clear when both happen in the same cycle.
      if (push_req && !push_ok)
        ov_q <= 1'b1;
      else if (bus.clr_status)
        ov_q <= 1'b0;
      if (push_ok && sh_bad)
        fe_q <= 1'b1;
      else if (bus.clr_status)
        fe_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.count     = cnt;
  assign bus.overflow  = ov_q;
  assign bus.float_err = fe_q;
endmodule

// File: tb/tb_bus_write_receiver.sv
// tb/tb_bus_write_receiver.sv - directed and randomized bench for bus_write_receiver with a queue model
module tb_bus_write_receiver;
  localparam logic [9:0] PA    = 10'h060;
  localparam int         DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_write_receiver_if #(.PTR_W(2)) bus ();

  bus_write_receiver #(.PORT_ADDR(PA), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int         due;
    logic [9:0] a;
    logic [7:0] v;
  } wr_t;

  wr_t        pend[$];
  logic [7:0] mq[$];
  logic       m_ov, m_fe;
  int         cyc, total, bad;
  bit         rnd_mode;
  logic [7:0] zv;
  logic [7:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A write whose strobe rises just after edge n is pushed at edge n+3 (two sync flops plus edge detect).
  task automatic model_step();
    wr_t        w;
    bit         pop, push, isbad, set_ov, accept;
    logic [7:0] b;
    if (reset) begin
      mq.delete();
      pend.delete();
      m_ov = 1'b0;
      m_fe = 1'b0;
      return;
    end
    cyc++;
    pop   = (mq.size() > 0) && (bus.out_ready === 1'b1);
    push  = 1'b0;
    isbad = 1'b0;
    b     = 8'h00;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      w = pend.pop_front();
      if (w.a == PA) begin
        push  = 1'b1;
        isbad = $isunknown(w.v);
        b     = isbad ? 8'hFF : w.v;
      end
    end
    set_ov = push && (mq.size() == DEPTH) && !pop;
    accept = push && !set_ov;
    if (pop)
      void'(mq.pop_front());
    if (accept)
      mq.push_back(b);
    m_ov = set_ov ? 1'b1 : (bus.clr_status ? 1'b0 : m_ov);
    m_fe = (accept && isbad) ? 1'b1 : (bus.clr_status ? 1'b0 : m_fe);
  endtask

  task automatic compare();
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ov));
    chk("float_err", 32'(bus.float_err), 32'(m_fe));
    if (mq.size() > 0)
      chk("out_data", 32'(bus.out_data), 32'(mq[0]));
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_mode) begin
      bus.out_ready  = 1'($urandom_range(0, 1));
      bus.clr_status = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] v, input int low, input bit pop_at_due);
    tick();
    bus.addr  = a;
    bus.d     = v;
    bus.iow_n = 1'b0;
    repeat (low) tick();
    bus.iow_n = 1'b1;
    pend.push_back('{cyc + 3, a, v});
    tick();
    tick();
    if (pop_at_due) bus.out_ready = 1'b1;
    tick();
    if (pop_at_due) bus.out_ready = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
  endtask

  initial begin
    bus.iow_n = 1'b1; bus.addr = '0; bus.d = '0;
    bus.out_ready = 1'b0; bus.clr_status = 1'b0;
    rnd_mode = 1'b0; total = 0; bad = 0; cyc = 0;
    m_ov = 1'b0; m_fe = 1'b0;
    zv = 8'hzz;
    fork
      forever begin
        @(posedge clk or posedge reset);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (!reset) compare();
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_float", 32'(bus.float_err), 0);
    chk("rst_data", 32'(bus.out_data), 0);

    // single write and pop
    do_write(PA, 8'hA5, 4, 1'b0);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", 32'(bus.out_data), 32'hA5);
    chk("single_count", 32'(bus.count), 1);
    pop_one();
    chk("single_popped_valid", 32'(bus.out_valid), 0);
    chk("single_popped_count", 32'(bus.count), 0);

    // address filter
    do_write(10'h061, 8'h3C, 4, 1'b0);
    repeat (2) tick();
    chk("filter_valid", 32'(bus.out_valid), 0);
    chk("filter_count", 32'(bus.count), 0);
    chk("filter_overflow", 32'(bus.overflow), 0);

    // ordering, full and overflow
    for (int i = 1; i <= 5; i++) do_write(PA, 8'(i), 4, 1'b0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_overflow", 32'(bus.overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("order_data", 32'(bus.out_data), 32'(i));
      pop_one();
    end
    chk("drained_count", 32'(bus.count), 0);
    clr_pulse();
    chk("ov_cleared", 32'(bus.overflow), 0);

    // push and pop together while full
    for (int i = 1; i <= 4; i++) do_write(PA, 8'(i), 3, 1'b0);
    do_write(PA, 8'h05, 3, 1'b1);
    chk("pushpop_count", 32'(bus.count), 4);
    chk("pushpop_overflow", 32'(bus.overflow), 0);
    for (int i = 2; i <= 5; i++) begin
      chk("pushpop_data", 32'(bus.out_data), 32'(i));
      pop_one();
    end

    // floating bus
    exp_b = $isunknown(zv) ? 8'hFF : zv;
    do_write(PA, zv, 4, 1'b0);
    chk("float_byte", 32'(bus.out_data), 32'(exp_b));
    chk("float_flag", 32'(bus.float_err), 32'($isunknown(zv)));
    do_write(PA, 8'h12, 4, 1'b0);
    chk("float_sticky", 32'(bus.float_err), 32'($isunknown(zv)));
    clr_pulse();
    chk("float_cleared", 32'(bus.float_err), 0);
    pop_one();
    chk("float_next_data", 32'(bus.out_data), 32'h12);
    pop_one();

    // asynchronous reset with entries queued and overflow pending
    for (int i = 1; i <= 5; i++) do_write(PA, 8'(8'h40 + i), 2, 1'b0);
    pop_one();
    chk("pre_rst_count", 32'(bus.count), 3);
    chk("pre_rst_overflow", 32'(bus.overflow), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    chk("arst_float", 32'(bus.float_err), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // randomized traffic
    rnd_mode = 1'b1;
    repeat (60) begin
      logic [9:0] a;
      logic [7:0] v;
      a = ($urandom_range(0, 3) != 0) ? PA : 10'($urandom);
      v = ($urandom_range(0, 9) == 0) ? zv : 8'($urandom);
      do_write(a, v, $urandom_range(1, 5), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rnd_mode = 1'b0;
    bus.clr_status = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    bus.out_ready = 1'b0;
    tick();
    chk("final_count", 32'(bus.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
